// File: rtl/instruction_fetch.sv
// rv32i fetch stage: owns the PC, keeps one instruction read in flight and
// buffers returned words with their PCs in a 2-entry queue for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        memory_request_valid,
    input  logic        memory_request_ready,
    output logic [31:0] memory_address,
    input  logic        memory_response_valid,
    input  logic [31:0] memory_response_data,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc
);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    state_t       state, next_state;
    logic [31:0]  pc, req_pc;
    fetch_entry_t fifo_mem [2];
    logic         rd_ptr, wr_ptr;
    logic [1:0]   count, count_after;
    logic         accept, push, pop;

    assign accept      = (state == REQUEST) && memory_request_ready;
    // A response that races a redirect belongs to the old stream and is dropped.
    assign push        = (state == WAIT) && memory_response_valid && !redirect_valid;
    assign pop         = (count != 2'd0) && instruction_ready;
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                // Nothing is outstanding here, so credit is just queue space.
                if (!redirect_valid && enable && count != 2'd2) next_state = REQUEST;
            end
            REQUEST: begin
                if (memory_request_ready) next_state = redirect_valid ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect_valid)
                    next_state = memory_response_valid ? IDLE : DROP;
                else if (memory_response_valid)
                    next_state = (enable && count_after != 2'd2) ? REQUEST : IDLE;
            end
            DROP: begin
                if (memory_response_valid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            req_pc <= '0;
        end else begin
            // A redirect wins even over an accepted request, so no +4 then.
            if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
            else if (accept)     pc <= pc + 32'd4;
            if (accept)          req_pc <= pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{instr: memory_response_data, pc: req_pc};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_after;
        end
    end

    always_comb begin
        memory_request_valid = (state == REQUEST);
        memory_address       = pc;
        instruction_valid    = (count != 2'd0);
        instruction          = fifo_mem[rd_ptr].instr;
        instruction_pc       = fifo_mem[rd_ptr].pc;
    end

endmodule
